// File: rtl/maze_pkg.sv
// maze_pkg: shared encodings for the fault-aware multicast splitter.
//   pkt_type_e : packet type field carried on the mesh links
//   state_e    : splitter control states
package maze_pkg;

  typedef enum logic [1:0] {
    PKT_UNI = 2'b00,
    PKT_COL = 2'b01,
    PKT_ROW = 2'b10,
    PKT_BC  = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PASS = 2'b01,
    REPL = 2'b10
  } state_e;

endpackage

// File: rtl/maze_coord_next.sv
// maze_coord_next: combinational destination enumerator.
//   start           : 1 = produce the first destination of the set,
//                     0 = produce the destination following (cur_x, cur_y)
//   pkt_type        : column / row / broadcast selects the walk order
//   cur_x, cur_y    : current destination (ignored when start=1)
//   tgt_x, tgt_y    : target fields fixing the column/row (used when start=1)
//   flt_x, flt_y    : faulty node, never produced
//   nxt_x, nxt_y    : produced destination
//   nxt_ok          : a non-faulty destination exists
//   nxt_is_last     : no non-faulty destination follows nxt_x/nxt_y
module maze_coord_next
  import maze_pkg::*;
#(
  parameter int MESH_X = 8,
  parameter int MESH_Y = 8,
  parameter int CW     = 3
) (
  input  logic          start,
  input  logic [1:0]    pkt_type,
  input  logic [CW-1:0] cur_x,
  input  logic [CW-1:0] cur_y,
  input  logic [CW-1:0] tgt_x,
  input  logic [CW-1:0] tgt_y,
  input  logic [CW-1:0] flt_x,
  input  logic [CW-1:0] flt_y,
  output logic [CW-1:0] nxt_x,
  output logic [CW-1:0] nxt_y,
  output logic          nxt_ok,
  output logic          nxt_is_last
);

  localparam logic [CW-1:0] MAX_X = CW'(MESH_X - 1);
  localparam logic [CW-1:0] MAX_Y = CW'(MESH_Y - 1);

  // One raw step of the walk, ignoring the fault. Stops at the mesh edge
  // instead of wrapping.
  function automatic void step(input logic [1:0] t, input logic [CW-1:0] x,
                               input logic [CW-1:0] y, output logic ok,
                               output logic [CW-1:0] nx, output logic [CW-1:0] ny);
    ok = 1'b0;
    nx = x;
    ny = y;
    case (t)
      PKT_COL: if (y != MAX_Y) begin ny = y + CW'(1); ok = 1'b1; end
      PKT_ROW: if (x != MAX_X) begin nx = x + CW'(1); ok = 1'b1; end
      PKT_BC: begin
        if (x != MAX_X) begin
          nx = x + CW'(1);
          ok = 1'b1;
        end else if (y != MAX_Y) begin
          nx = '0;
          ny = y + CW'(1);
          ok = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  logic          a_ok, b_ok, c_ok, d_ok;
  logic [CW-1:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;

  // There is a single faulty node, so one extra step always clears it;
  // the second pair of steps looks ahead to flag the final destination.
  always_comb begin
    if (start) begin
      a_ok = 1'b1;
      a_x  = (pkt_type == PKT_COL) ? tgt_x : '0;
      a_y  = (pkt_type == PKT_ROW) ? tgt_y : '0;
    end else begin
      step(pkt_type, cur_x, cur_y, a_ok, a_x, a_y);
    end

    if (a_ok && (a_x == flt_x) && (a_y == flt_y)) begin
      step(pkt_type, a_x, a_y, b_ok, b_x, b_y);
    end else begin
      b_ok = a_ok;
      b_x  = a_x;
      b_y  = a_y;
    end

    step(pkt_type, b_x, b_y, c_ok, c_x, c_y);
    if (c_ok && (c_x == flt_x) && (c_y == flt_y)) begin
      step(pkt_type, c_x, c_y, d_ok, d_x, d_y);
    end else begin
      d_ok = c_ok;
      d_x  = c_x;
      d_y  = c_y;
    end

    nxt_x       = b_x;
    nxt_y       = b_y;
    nxt_ok      = b_ok;
    nxt_is_last = !d_ok;
  end

endmodule

// File: rtl/fault_mcast_splitter.sv
// fault_mcast_splitter: turns multicast/broadcast packets into serial
// unicast copies when a faulty node exists, skipping the faulty node.
//   in_*     : accepted packet (valid/ready handshake)
//   pg_*     : fault mode, captured together with the packet
//   out_*    : emitted packet or unicast copy (valid/ready handshake),
//              out_last marks the final copy of a packet
//   busy     : replication in progress
//   drop     : one-cycle pulse when an accepted packet has no destination
module fault_mcast_splitter
  import maze_pkg::*;
#(
  parameter int MESH_X = 8,
  parameter int MESH_Y = 8,
  parameter int CW     = 3,
  parameter int PW     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_pkt_type,
  input  logic [CW-1:0] in_src_x,
  input  logic [CW-1:0] in_src_y,
  input  logic [CW-1:0] in_tgt_x,
  input  logic [CW-1:0] in_tgt_y,
  input  logic [PW-1:0] in_payload,
  input  logic          pg_en,
  input  logic [CW-1:0] pg_x,
  input  logic [CW-1:0] pg_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_pkt_type,
  output logic [CW-1:0] out_src_x,
  output logic [CW-1:0] out_src_y,
  output logic [CW-1:0] out_tgt_x,
  output logic [CW-1:0] out_tgt_y,
  output logic [PW-1:0] out_payload,
  output logic          out_last,
  output logic          busy,
  output logic          drop
);

  state_e        state_reg;
  pkt_type_e     mc_type_reg;
  logic [CW-1:0] flt_x_reg, flt_y_reg;

  logic          accept, is_pass;
  logic [1:0]    cn_type;
  logic [CW-1:0] cn_flt_x, cn_flt_y, cn_nxt_x, cn_nxt_y;
  logic          cn_ok, cn_is_last;

  // The final handshake of a packet frees the slot in the same cycle.
  assign in_ready = !rst && ((state_reg == IDLE) || (out_valid && out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign is_pass  = !pg_en || (in_pkt_type == PKT_UNI);

  // On acceptance the enumerator looks at the incoming packet to find the
  // first copy; otherwise it walks on from the copy currently presented.
  assign cn_type  = accept ? in_pkt_type : mc_type_reg;
  assign cn_flt_x = accept ? pg_x : flt_x_reg;
  assign cn_flt_y = accept ? pg_y : flt_y_reg;

  maze_coord_next #(
    .MESH_X(MESH_X),
    .MESH_Y(MESH_Y),
    .CW    (CW)
  ) u_coord_next (
    .start      (accept),
    .pkt_type   (cn_type),
    .cur_x      (out_tgt_x),
    .cur_y      (out_tgt_y),
    .tgt_x      (in_tgt_x),
    .tgt_y      (in_tgt_y),
    .flt_x      (cn_flt_x),
    .flt_y      (cn_flt_y),
    .nxt_x      (cn_nxt_x),
    .nxt_y      (cn_nxt_y),
    .nxt_ok     (cn_ok),
    .nxt_is_last(cn_is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mc_type_reg  <= PKT_UNI;
      flt_x_reg    <= '0;
      flt_y_reg    <= '0;
      out_valid    <= 1'b0;
      out_pkt_type <= '0;
      out_src_x    <= '0;
      out_src_y    <= '0;
      out_tgt_x    <= '0;
      out_tgt_y    <= '0;
      out_payload  <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      drop         <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (accept) begin
        out_src_x   <= in_src_x;
        out_src_y   <= in_src_y;
        out_payload <= in_payload;
        if (is_pass) begin
          state_reg    <= PASS;
          out_valid    <= 1'b1;
          out_last     <= 1'b1;
          busy         <= 1'b0;
          out_pkt_type <= in_pkt_type;
          out_tgt_x    <= in_tgt_x;
          out_tgt_y    <= in_tgt_y;
        end else begin
          mc_type_reg  <= pkt_type_e'(in_pkt_type);
          flt_x_reg    <= pg_x;
          flt_y_reg    <= pg_y;
          out_pkt_type <= PKT_UNI;
          out_tgt_x    <= cn_nxt_x;
          out_tgt_y    <= cn_nxt_y;
          if (cn_ok) begin
            state_reg <= REPL;
            out_valid <= 1'b1;
            out_last  <= cn_is_last;
            busy      <= 1'b1;
          end else begin
            // Every destination of the set is the faulty node.
            state_reg <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b1;
          end
        end
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          out_tgt_x <= cn_nxt_x;
          out_tgt_y <= cn_nxt_y;
          out_last  <= cn_is_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_fault_mcast_splitter.sv
// tb_fault_mcast_splitter: directed bench with a destination-set model.
// The model expands each accepted packet into its full list of expected
// copies; a negedge process compares every output cycle against it.
module tb_fault_mcast_splitter;

  localparam int MX = 8;
  localparam int MY = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_pkt_type = '0;
  logic [2:0]  in_src_x = '0, in_src_y = '0, in_tgt_x = '0, in_tgt_y = '0;
  logic [63:0] in_payload = '0;
  logic        pg_en = 1'b0;
  logic [2:0]  pg_x = '0, pg_y = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [1:0]  out_pkt_type;
  logic [2:0]  out_src_x, out_src_y, out_tgt_x, out_tgt_y;
  logic [63:0] out_payload;
  logic        out_last, busy, drop;

  logic        d2_in_valid = 1'b0, d2_in_ready;
  logic [1:0]  d2_in_pkt_type = '0;
  logic [2:0]  d2_in_tgt_y = '0, d2_pg_x = '0, d2_pg_y = '0;
  logic        d2_pg_en = 1'b0;
  logic        d2_out_valid, d2_out_last, d2_busy, d2_drop;
  logic [1:0]  d2_out_pkt_type;
  logic [2:0]  d2_out_src_x, d2_out_src_y, d2_out_tgt_x, d2_out_tgt_y;
  logic [63:0] d2_out_payload;

  fault_mcast_splitter #(.MESH_X(MX), .MESH_Y(MY), .CW(3), .PW(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pkt_type(in_pkt_type), .in_src_x(in_src_x), .in_src_y(in_src_y),
    .in_tgt_x(in_tgt_x), .in_tgt_y(in_tgt_y), .in_payload(in_payload),
    .pg_en(pg_en), .pg_x(pg_x), .pg_y(pg_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt_type(out_pkt_type),
    .out_src_x(out_src_x), .out_src_y(out_src_y), .out_tgt_x(out_tgt_x),
    .out_tgt_y(out_tgt_y), .out_payload(out_payload), .out_last(out_last),
    .busy(busy), .drop(drop)
  );

  fault_mcast_splitter #(.MESH_X(1), .MESH_Y(8), .CW(3), .PW(64)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_pkt_type(d2_in_pkt_type), .in_src_x(3'd0), .in_src_y(3'd1),
    .in_tgt_x(3'd0), .in_tgt_y(d2_in_tgt_y), .in_payload(64'h1234),
    .pg_en(d2_pg_en), .pg_x(d2_pg_x), .pg_y(d2_pg_y),
    .out_valid(d2_out_valid), .out_ready(1'b1), .out_pkt_type(d2_out_pkt_type),
    .out_src_x(d2_out_src_x), .out_src_y(d2_out_src_y), .out_tgt_x(d2_out_tgt_x),
    .out_tgt_y(d2_out_tgt_y), .out_payload(d2_out_payload), .out_last(d2_out_last),
    .busy(d2_busy), .drop(d2_drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [2:0]  sx, sy, tx, ty;
    logic [63:0] p;
    bit          last;
    bit          repl;
  } exp_t;

  exp_t       q[$];
  bit         drop_pend = 0;
  int         hs_count = 0;
  int         b2b_count = 0;
  int         pkt_seen = 0;
  logic [5:0] first_xy = '0;
  logic [2:0] ys_log[$];
  logic [5:0] last_log[$];
  bit         rand_mode = 0;

  // Expected copies of a packet: every node of its destination set except
  // the faulty one, y outer / x inner ascending.
  always @(negedge clk) begin
    exp_t e;
    exp_t tmp[$];
    bit   popped_last;
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      q.delete();
      drop_pend = 0;
    end else begin
      popped_last = 0;
      chk("out_valid", out_valid, q.size() > 0);
      chk("busy", busy, (q.size() > 0) ? q[0].repl : 1'b0);
      chk("drop", drop, drop_pend);
      chk("in_ready", in_ready, (q.size() == 0) || (out_ready && q[0].last));
      if (q.size() > 0 && out_valid) begin
        e = q[0];
        chk("out_pkt_type", out_pkt_type, e.t);
        chk("out_src_x", out_src_x, e.sx);
        chk("out_src_y", out_src_y, e.sy);
        chk("out_tgt_x", out_tgt_x, e.tx);
        chk("out_tgt_y", out_tgt_y, e.ty);
        chk("out_payload", out_payload, e.p);
        chk("out_last", out_last, e.last);
        if (out_ready) begin
          hs_count++;
          if (hs_count == 1) first_xy = {out_tgt_x, out_tgt_y};
          ys_log.push_back(out_tgt_y);
          if (out_last) last_log.push_back({out_tgt_x, out_tgt_y});
          popped_last = e.last;
          void'(q.pop_front());
        end
      end
      drop_pend = 0;
      if (in_valid && in_ready) begin
        tmp.delete();
        if (!pg_en || in_pkt_type == 2'b00) begin
          e = '{t: in_pkt_type, sx: in_src_x, sy: in_src_y, tx: in_tgt_x, ty: in_tgt_y,
                p: in_payload, last: 1, repl: 0};
          tmp.push_back(e);
        end else begin
          for (int y = 0; y < MY; y++) begin
            for (int x = 0; x < MX; x++) begin
              bit inset;
              inset = (in_pkt_type == 2'b11) ||
                      (in_pkt_type == 2'b01 && x == in_tgt_x) ||
                      (in_pkt_type == 2'b10 && y == in_tgt_y);
              if (inset && !(x == pg_x && y == pg_y)) begin
                e = '{t: 2'b00, sx: in_src_x, sy: in_src_y, tx: x[2:0], ty: y[2:0],
                      p: in_payload, last: 0, repl: 1};
                tmp.push_back(e);
              end
            end
          end
        end
        for (int i = 0; i < tmp.size(); i++) begin
          e = tmp[i];
          e.last = (i == tmp.size() - 1);
          q.push_back(e);
        end
        if (tmp.size() == 0) drop_pend = 1;
        if (popped_last) b2b_count++;
        pkt_seen++;
        $display("pkt %0d accepted: type=%0d tgt=(%0d,%0d) pg_en=%0d pg=(%0d,%0d) copies=%0d",
                 pkt_seen, in_pkt_type, in_tgt_x, in_tgt_y, pg_en, pg_x, pg_y, tmp.size());
      end
    end
  end

  // The small instance never has anything to emit in this bench.
  always @(negedge clk) begin
    if (!rst) chk("d2_out_valid", d2_out_valid, 0);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    hs_count = 0;
    b2b_count = 0;
    ys_log.delete();
    last_log.delete();
  endtask

  function automatic logic [5:0] last_at(input int i);
    return (i < last_log.size()) ? last_log[i] : 6'bx;
  endfunction

  task automatic send(input logic [1:0] t, input logic [2:0] tx, input logic [2:0] ty,
                      input logic pe, input logic [2:0] px, input logic [2:0] py);
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_pkt_type = t;
    in_tgt_x = tx;
    in_tgt_y = ty;
    in_src_x = 3'($urandom);
    in_src_y = 3'($urandom);
    in_payload = {$urandom, $urandom};
    pg_en = pe;
    pg_x = px;
    pg_y = py;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble fault inputs: the packet in flight must not notice.
    pg_en = 1'($urandom);
    pg_x = 3'($urandom);
    pg_y = 3'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (q.size() == 0 && !in_valid) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  int exp_col[7] = '{0, 1, 2, 3, 5, 6, 7};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_out_tgt", {out_tgt_x, out_tgt_y}, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_in_ready", in_ready, 1);

    // Plain unicast pass-through
    clear_logs();
    send(2'b00, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    chk("uni_valid", out_valid, 1);
    chk("uni_tgt", {out_tgt_x, out_tgt_y}, {3'd3, 3'd5});
    chk("uni_last", out_last, 1);
    wait_idle();
    chk("uni_count", hs_count, 1);

    // Unicast with a fault on its own target is still passed unchanged
    clear_logs();
    send(2'b00, 3'd2, 3'd2, 1'b1, 3'd2, 3'd2);
    wait_idle();
    chk("uni_pg_count", hs_count, 1);
    chk("uni_pg_last", last_at(0), {3'd2, 3'd2});

    // Multicast without a fault is passed as one packet
    clear_logs();
    send(2'b01, 3'd6, 3'd1, 1'b0, 3'd6, 3'd3);
    @(negedge clk);
    chk("col_nofault_type", out_pkt_type, 2'b01);
    wait_idle();
    chk("col_nofault_count", hs_count, 1);

    // Column multicast, fault mid-column
    clear_logs();
    send(2'b01, 3'd2, 3'd0, 1'b1, 3'd2, 3'd4);
    wait_idle();
    chk("col_count", hs_count, 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("col_y%0d", i), (i < ys_log.size()) ? ys_log[i] : 3'bx, exp_col[i]);
    chk("col_last", last_at(0), {3'd2, 3'd7});

    // Row multicast, fault on the final coordinate
    clear_logs();
    send(2'b10, 3'd0, 3'd1, 1'b1, 3'd7, 3'd1);
    wait_idle();
    chk("row_count", hs_count, 7);
    chk("row_last", last_at(0), {3'd6, 3'd1});

    // Broadcast with stalls, followed back-to-back by a unicast
    clear_logs();
    rand_mode = 1;
    send(2'b11, 3'd4, 3'd4, 1'b1, 3'd0, 3'd0);
    send(2'b00, 3'd5, 3'd5, 1'b0, 3'd0, 3'd0);
    wait_idle();
    rand_mode = 0;
    chk("bc_count", hs_count, 64);
    chk("bc_first", first_xy, {3'd1, 3'd0});
    chk("bc_last", last_at(0), {3'd7, 3'd7});
    chk("b2b_last", last_at(1), {3'd5, 3'd5});
    chk("b2b_count", b2b_count, 1);

    // Column multicast, fault on the first coordinate
    clear_logs();
    send(2'b01, 3'd4, 3'd0, 1'b1, 3'd4, 3'd0);
    wait_idle();
    chk("col0_count", hs_count, 7);
    chk("col0_first", first_xy, {3'd4, 3'd1});

    // Row multicast, fault elsewhere
    clear_logs();
    send(2'b10, 3'd0, 3'd2, 1'b1, 3'd3, 3'd5);
    wait_idle();
    chk("row_off_count", hs_count, 8);
    chk("row_off_last", last_at(0), {3'd7, 3'd2});

    // Reset in the middle of a broadcast
    clear_logs();
    send(2'b11, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (hs_count >= 3) break;
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_count", hs_count, 3);
    repeat (5) @(negedge clk);
    chk("mrst_no_resume", out_valid, 0);

    // Normal traffic after reset
    clear_logs();
    send(2'b00, 3'd1, 3'd6, 1'b0, 3'd0, 3'd0);
    wait_idle();
    chk("post_rst_count", hs_count, 1);
    chk("post_rst_last", last_at(0), {3'd1, 3'd6});

    // Single-column mesh: row multicast whose only node is faulty
    @(posedge clk);
    #1;
    d2_in_valid = 1'b1;
    d2_in_pkt_type = 2'b10;
    d2_in_tgt_y = 3'd3;
    d2_pg_en = 1'b1;
    d2_pg_x = 3'd0;
    d2_pg_y = 3'd3;
    @(negedge clk);
    chk("d2_in_ready", d2_in_ready, 1);
    @(posedge clk);
    #1 d2_in_valid = 1'b0;
    @(negedge clk);
    chk("d2_drop_pulse", d2_drop, 1);
    chk("d2_busy", d2_busy, 0);
    @(negedge clk);
    chk("d2_drop_end", d2_drop, 0);
    chk("d2_ready_again", d2_in_ready, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
